gallery_controller: RTL and testbench
=====================================

Name: gallery_controller

Overview:
Sequences the image gallery from the debounced button pulses: it owns the slot-occupancy bitmap and the displayed image index. Navigation skips slots that have been deleted. A delete request runs a clear pass that zeroes the deleted slot in frame memory through a ready/valid write port, then moves the display to the next occupied slot. It sits between the button front end and the frame-memory write arbiter; the display path reads image_index and blank.

Parameters:
IDX_W, 2, slot index width; NSLOTS = 2^IDX_W
WORD_AW, 8, word-address width inside one slot; SLOT_WORDS = 2^WORD_AW
DATA_W, 12, frame-memory data width

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
next_pulse  in  1  one-cycle request to move to the next occupied slot
prev_pulse  in  1  one-cycle request to move to the previous occupied slot
delete_pulse  in  1  one-cycle request to delete the displayed slot
restore_pulse  in  1  one-cycle request to mark all slots occupied
mem_ready  in  1  frame-memory write accepted this cycle when mem_we=1
mem_we  out  1  write request to frame memory
mem_addr  out  IDX_W+WORD_AW  write address {slot, word}
mem_wdata  out  DATA_W  write data, constant 0
image_index  out  IDX_W  slot currently displayed
slot_valid  out  NSLOTS  occupancy bitmap; bit i = slot i holds an image
blank  out  1  high when slot_valid is all zeros
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: image_index=0, slot_valid=all ones, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, blank=0, FSM=IDLE, internal counters=0.
- blank and busy are combinational from registered state. blank = ~|slot_valid. busy = (state!=IDLE).
- States: IDLE, SEEK_FWD, SEEK_BWD, CLEAR.
- IDLE accepts one event per cycle. Priority is delete > next > prev > restore. Lower-priority events in the same cycle are dropped.
- Any pulse that arrives while busy=1 is dropped. There is no queuing.
- next: enter SEEK_FWD with cand=image_index+1 (mod NSLOTS) and step counter=1.
- prev: enter SEEK_BWD with cand=image_index-1 (mod NSLOTS) and step counter=1.
- SEEK, each cycle:
  - If slot_valid[cand]=1: image_index<=cand, go to IDLE.
  - Else if step==NSLOTS-1: image_index is unchanged, go to IDLE.
  - Else: cand steps ±1 with wrap, step increments.
  - Latency from pulse to image_index update is d+1 cycles, where d is the slot distance. The worst case returns to IDLE after NSLOTS cycles.
  - When only the current slot is valid, or no slot is valid, image_index is held.
- delete:
  - If slot_valid[image_index]=0, the request is ignored and the FSM stays in IDLE.
  - Otherwise, on the next edge: slot_valid[image_index]<=0, word_cnt<=0, mem_we<=1, mem_addr<={image_index,0}, enter CLEAR.
- CLEAR:
  - mem_we stays high. mem_addr and mem_wdata stay stable while mem_ready=0.
  - On each cycle with mem_we&&mem_ready, word_cnt increments and mem_addr advances.
  - When the word SLOT_WORDS-1 is accepted: mem_we<=0, then enter SEEK_FWD from image_index+1.
  - Exactly SLOT_WORDS writes occur, to addresses {slot,0}..{slot,SLOT_WORDS-1}. No write is duplicated or skipped.
  - The minimum delete duration with mem_ready tied high is SLOT_WORDS cycles plus the seek.
- restore (IDLE only): slot_valid<=all ones in one cycle. image_index is unchanged, no memory traffic.
- mem_we is never high outside CLEAR.
- reset asserted mid-CLEAR aborts the pass immediately: mem_we drops asynchronously and all state returns to reset values. The partially cleared slot reads as valid again after reset (contents undefined).
- Wrap-around on image_index and cand is modulo NSLOTS. Arithmetic is IDX_W wide with natural overflow.

Test Plan:
1. After reset, send next ×4 with ≥NSLOTS idle cycles between pulses → image_index goes 1,2,3,0. Then prev → 3.
2. image_index=1, mem_ready=1, delete → slot_valid=4'b1101. mem_we is high for exactly 256 cycles with mem_addr 0x100..0x1FF, data 0. Then image_index=2 and busy=0.
3. Repeat scenario 2 with mem_ready toggling pseudo-randomly → still exactly 256 accepted writes in order. mem_addr is held during every stalled cycle.
4. Delete all four slots in sequence → blank=1, image_index holds, and a further delete produces no mem_we. Then restore → slot_valid=4'b1111, blank=0.
5. Pulse next and prev during CLEAR, and delete+next in the same IDLE cycle → events during CLEAR are ignored and only the delete executes.
6. Assert reset when word_cnt=100 in CLEAR → mem_we=0 immediately, image_index=0, slot_valid=4'b1111, busy=0.

Source files
------------

// File: rtl/gallery_controller.sv
// rtl/gallery_controller.sv - image gallery sequencer: slot occupancy, displayed index, slot clear pass
//
// Ports:
//   clk, reset        system clock; asynchronous active-high reset
//   next_pulse        move to the next occupied slot (one cycle)
//   prev_pulse        move to the previous occupied slot (one cycle)
//   delete_pulse      delete the displayed slot and zero it in frame memory
//   restore_pulse     mark every slot occupied again
//   mem_ready         frame memory accepts the current write this cycle
//   mem_we            frame-memory write request (only during a clear pass)
//   mem_addr          write address {slot, word}
//   mem_wdata         write data, always zero
//   image_index       slot currently displayed
//   slot_valid        occupancy bitmap, bit i = slot i holds an image
//   blank             no slot holds an image
//   busy              a seek or clear pass is in progress
module gallery_controller #(
    parameter int IDX_W   = 2,
    parameter int WORD_AW = 8,
    parameter int DATA_W  = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       next_pulse,
    input  logic                       prev_pulse,
    input  logic                       delete_pulse,
    input  logic                       restore_pulse,
    input  logic                       mem_ready,
    output logic                       mem_we,
    output logic [IDX_W+WORD_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [IDX_W-1:0]           image_index,
    output logic [(1<<IDX_W)-1:0]      slot_valid,
    output logic                       blank,
    output logic                       busy
);

    localparam int NSLOTS = 1 << IDX_W;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SEEK_FWD = 2'd1;
    localparam logic [1:0] S_SEEK_BWD = 2'd2;
    localparam logic [1:0] S_CLEAR    = 2'd3;

    localparam logic [IDX_W-1:0]   ONE_IDX   = IDX_W'(1);
    // A seek gives up after probing every other slot once.
    localparam logic [IDX_W-1:0]   LAST_STEP = IDX_W'(NSLOTS - 1);
    localparam logic [WORD_AW-1:0] LAST_WORD = {WORD_AW{1'b1}};

    logic [1:0]         state;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   step;
    logic [WORD_AW-1:0] word_cnt;

    assign mem_wdata = '0;
    assign blank     = ~|slot_valid;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            image_index <= '0;
            slot_valid  <= '1;
            cand        <= '0;
            step        <= '0;
            word_cnt    <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Delete wins even when it is ignored, so a delete on an
                    // empty slot still swallows a simultaneous next/prev.
                    if (delete_pulse) begin
                        if (slot_valid[image_index]) begin
                            slot_valid[image_index] <= 1'b0;
                            word_cnt <= '0;
                            mem_we   <= 1'b1;
                            mem_addr <= {image_index, {WORD_AW{1'b0}}};
                            state    <= S_CLEAR;
                        end
                    end else if (next_pulse) begin
                        cand  <= image_index + ONE_IDX;
                        step  <= ONE_IDX;
                        state <= S_SEEK_FWD;
                    end else if (prev_pulse) begin
                        cand  <= image_index - ONE_IDX;
                        step  <= ONE_IDX;
                        state <= S_SEEK_BWD;
                    end else if (restore_pulse) begin
                        slot_valid <= '1;
                    end
                end

                S_SEEK_FWD, S_SEEK_BWD: begin
                    if (slot_valid[cand]) begin
                        image_index <= cand;
                        state       <= S_IDLE;
                    end else if (step == LAST_STEP) begin
                        state <= S_IDLE;
                    end else begin
                        cand <= (state == S_SEEK_FWD) ? cand + ONE_IDX : cand - ONE_IDX;
                        step <= step + ONE_IDX;
                    end
                end

                S_CLEAR: begin
                    // Address and data only move on an accepted write, so a
                    // stalled request is presented unchanged.
                    if (mem_ready) begin
                        if (word_cnt == LAST_WORD) begin
                            mem_we <= 1'b0;
                            cand   <= image_index + ONE_IDX;
                            step   <= ONE_IDX;
                            state  <= S_SEEK_FWD;
                        end else begin
                            word_cnt <= word_cnt + WORD_AW'(1);
                            mem_addr <= {image_index, word_cnt + WORD_AW'(1)};
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gallery_controller.sv
// tb/tb_gallery_controller.sv - self-checking bench for gallery_controller
module tb_gallery_controller;

    localparam int NS = 4;
    localparam int SW = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        next_pulse = 1'b0;
    logic        prev_pulse = 1'b0;
    logic        delete_pulse = 1'b0;
    logic        restore_pulse = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic [1:0]  image_index;
    logic [3:0]  slot_valid;
    logic        blank;
    logic        busy;

    int checks = 0;
    int errors = 0;

    gallery_controller dut (
        .clk           (clk),
        .reset         (reset),
        .next_pulse    (next_pulse),
        .prev_pulse    (prev_pulse),
        .delete_pulse  (delete_pulse),
        .restore_pulse (restore_pulse),
        .mem_ready     (mem_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .image_index   (image_index),
        .slot_valid    (slot_valid),
        .blank         (blank),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 seeking, 2 clearing.
    typedef struct {
        int         idx;
        logic [3:0] valid;
        int         phase;
        int         left;
        int         target;
        bit         found;
        int         word;
    } model_t;

    model_t m;

    // Distance to the nearest occupied slot in a direction, 0 if none.
    function automatic int find_dist(int idx, int dir, logic [3:0] v);
        for (int k = 1; k < NS; k++)
            if (v[(idx + dir * k + 2 * NS) % NS]) return k;
        return 0;
    endfunction

    function automatic model_t start_seek(model_t s, int dir);
        int d;
        d = find_dist(s.idx, dir, s.valid);
        s.phase  = 1;
        s.found  = (d != 0);
        s.target = (s.idx + dir * d + 2 * NS) % NS;
        s.left   = (d != 0) ? d : NS - 1;
        return s;
    endfunction

    function automatic model_t model_reset();
        model_t s;
        s.idx = 0; s.valid = 4'hF; s.phase = 0; s.left = 0;
        s.target = 0; s.found = 0; s.word = 0;
        return s;
    endfunction

    function automatic model_t model_step(model_t s, logic del, logic nxt, logic prv,
                                          logic rst, logic rdy);
        case (s.phase)
            0: begin
                if (del) begin
                    if (s.valid[s.idx]) begin
                        s.valid[s.idx] = 1'b0;
                        s.phase = 2;
                        s.word  = 0;
                    end
                end else if (nxt) s = start_seek(s, 1);
                else if (prv)     s = start_seek(s, -1);
                else if (rst)     s.valid = 4'hF;
            end
            1: begin
                s.left--;
                if (s.left == 0) begin
                    if (s.found) s.idx = s.target;
                    s.phase = 0;
                end
            end
            default: begin
                if (rdy) begin
                    s.word++;
                    if (s.word == SW) s = start_seek(s, 1);
                end
            end
        endcase
        return s;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m, delete_pulse, next_pulse, prev_pulse, restore_pulse, mem_ready);
    end

    always @(negedge clk) begin
        chk("idx", 32'(image_index), 32'(m.idx));
        chk("valid", 32'(slot_valid), 32'(m.valid));
        chk("busy", 32'(busy), 32'(m.phase != 0));
        chk("blank", 32'(blank), 32'(m.valid == 4'h0));
        chk("mem_we", 32'(mem_we), 32'(m.phase == 2));
        chk("wdata", 32'(mem_wdata), 32'h0);
        if (m.phase == 2) chk("mem_addr", 32'(mem_addr), 32'(m.idx * SW + m.word));
    end

    // Handshake monitor, sampled mid-cycle; the write completes at the next edge.
    int acc_cnt = 0;
    int we_cnt = 0;
    logic [9:0] last_acc_addr = '0;
    always @(negedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_we && mem_ready) begin
            acc_cnt <= acc_cnt + 1;
            last_acc_addr <= mem_addr;
        end
    end

    task automatic pulse(input bit d, input bit n, input bit p, input bit r);
        @(posedge clk); #2;
        delete_pulse = d; next_pulse = n; prev_pulse = p; restore_pulse = r;
        @(posedge clk); #2;
        delete_pulse = 0; next_pulse = 0; prev_pulse = 0; restore_pulse = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int bound, input bit rnd);
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (!busy) begin
                mem_ready = 1'b1;
                return;
            end
            @(posedge clk); #2;
            if (rnd) mem_ready = 1'($urandom_range(0, 1));
        end
        mem_ready = 1'b1;
        chk("wait_idle_timeout", 32'(busy), 32'h0);
    endtask

    int acc_base, we_base;
    int exp_seq [4] = '{1, 2, 3, 0};

    initial begin
        idle(2);
        #1;
        chk("rst_idx", 32'(image_index), 32'h0);
        chk("rst_valid", 32'(slot_valid), 32'hF);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_blank", 32'(blank), 32'h0);
        reset = 1'b0;
        idle(2);

        // Navigation with wrap in both directions.
        for (int i = 0; i < 4; i++) begin
            pulse(0, 1, 0, 0);
            wait_idle(50, 0);
            idle(NS);
            chk("next_seq", 32'(image_index), 32'(exp_seq[i]));
        end
        pulse(0, 0, 1, 0);
        wait_idle(50, 0);
        chk("prev_wrap", 32'(image_index), 32'h3);
        pulse(0, 0, 1, 0); wait_idle(50, 0);
        pulse(0, 0, 1, 0); wait_idle(50, 0);
        chk("prev_to_1", 32'(image_index), 32'h1);

        // Delete slot 1 with memory always ready.
        acc_base = acc_cnt; we_base = we_cnt;
        pulse(1, 0, 0, 0);
        #1;
        chk("clear_first_we", 32'(mem_we), 32'h1);
        chk("clear_first_addr", 32'(mem_addr), 32'h100);
        wait_idle(1000, 0);
        chk("del_valid", 32'(slot_valid), 32'hD);
        chk("del_idx", 32'(image_index), 32'h2);
        chk("del_we_cycles", 32'(we_cnt - we_base), 32'(SW));
        chk("del_writes", 32'(acc_cnt - acc_base), 32'(SW));
        chk("del_last_addr", 32'(last_acc_addr), 32'h1FF);

        // Same delete under a stalling memory.
        pulse(0, 0, 0, 1); idle(1);
        chk("restore1", 32'(slot_valid), 32'hF);
        pulse(0, 0, 1, 0); wait_idle(50, 0);
        acc_base = acc_cnt;
        pulse(1, 0, 0, 0);
        wait_idle(4000, 1);
        chk("stall_writes", 32'(acc_cnt - acc_base), 32'(SW));
        chk("stall_last_addr", 32'(last_acc_addr), 32'h1FF);
        chk("stall_idx", 32'(image_index), 32'h2);

        // Pulses during CLEAR are dropped; delete beats next in the same cycle.
        pulse(0, 0, 0, 1); idle(1);
        pulse(1, 0, 0, 0);
        idle(10);
        pulse(0, 1, 0, 0);
        idle(10);
        pulse(0, 0, 1, 0);
        wait_idle(1000, 0);
        chk("busy_drop_valid", 32'(slot_valid), 32'hB);
        chk("busy_drop_idx", 32'(image_index), 32'h3);
        pulse(1, 1, 0, 0);
        wait_idle(1000, 0);
        chk("del_next_valid", 32'(slot_valid), 32'h3);
        chk("del_next_idx", 32'(image_index), 32'h0);

        // Empty the gallery, then restore.
        pulse(0, 0, 0, 1); idle(1);
        for (int i = 0; i < 4; i++) begin
            pulse(1, 0, 0, 0);
            wait_idle(1000, 0);
        end
        chk("empty_blank", 32'(blank), 32'h1);
        chk("empty_idx", 32'(image_index), 32'h3);
        we_base = we_cnt;
        pulse(1, 0, 0, 0);
        idle(5);
        chk("empty_del_we", 32'(we_cnt - we_base), 32'h0);
        chk("empty_del_busy", 32'(busy), 32'h0);
        pulse(0, 0, 0, 1); idle(1);
        chk("restore_valid", 32'(slot_valid), 32'hF);
        chk("restore_blank", 32'(blank), 32'h0);
        chk("restore_idx", 32'(image_index), 32'h3);

        // Reset in the middle of a clear pass.
        acc_base = acc_cnt;
        pulse(1, 0, 0, 0);
        for (int n = 0; n < 400 && (acc_cnt - acc_base) < 100; n++) @(negedge clk);
        chk("reach_word_100", 32'(acc_cnt - acc_base), 32'd100);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("abort_we", 32'(mem_we), 32'h0);
        chk("abort_idx", 32'(image_index), 32'h0);
        chk("abort_valid", 32'(slot_valid), 32'hF);
        chk("abort_busy", 32'(busy), 32'h0);
        idle(2);
        reset = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
